// File: rtl/fetch_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_seq_if
//  Brief    : Control/address bundle between the fetch sequencer and the
//             hazard unit, D-stage branch resolution, CP0 and the IM.
//  Revision : 1.0  initial release
// ============================================================================
interface fetch_seq_if;
    logic        stall_i;
    logic        d_redirect_i;
    logic [31:0] d_target_i;
    logic        d_is_cti_i;
    logic        exc_req_i;
    logic        eret_i;
    logic [31:0] epc_i;
    logic [31:0] f_pc_o;
    logic        f_valid_o;
    logic        f_bd_o;
    logic        f_adel_o;
    logic        flush_fd_o;
    logic [31:0] fetch_cnt_o;

    modport master (
        output stall_i, d_redirect_i, d_target_i, d_is_cti_i,
               exc_req_i, eret_i, epc_i,
        input  f_pc_o, f_valid_o, f_bd_o, f_adel_o, flush_fd_o, fetch_cnt_o
    );

    modport slave (
        input  stall_i, d_redirect_i, d_target_i, d_is_cti_i,
               exc_req_i, eret_i, epc_i,
        output f_pc_o, f_valid_o, f_bd_o, f_adel_o, flush_fd_o, fetch_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/fetch_seq.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_seq
//  Brief    : F-stage PC owner; selects hold / +4 / branch / exception target.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC  = 32'h0000_4180,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter logic [31:0] IM_TOP   = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,
    fetch_seq_if.slave  bus
);

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_fetch_cnt;
    logic        w_valid;
    logic        w_flush;
    logic        w_adel;
    logic        w_cnt_en;

    always_comb begin
        w_valid  = (r_state != S_BOOT);
        w_flush  = w_valid & (bus.exc_req_i | bus.eret_i);
        w_adel   = w_valid & ((r_pc[1:0] != 2'b00) | (r_pc < IM_BASE) | (r_pc > IM_TOP));
        w_cnt_en = w_valid & ~bus.stall_i & ~w_flush;
    end

    // Priority: exception > eret > stall > D redirect > sequential.
    always_comb begin
        w_pc_nxt    = r_pc;
        w_state_nxt = r_state;
        if (r_state == S_BOOT) begin
            w_state_nxt = S_RUN;
        end else if (bus.exc_req_i) begin
            w_pc_nxt    = EXC_VEC;
            w_state_nxt = S_RUN;
        end else if (bus.eret_i) begin
            w_pc_nxt    = bus.epc_i;
            w_state_nxt = S_RUN;
        end else if (bus.stall_i) begin
            w_state_nxt = S_HOLD;
        end else if (bus.d_redirect_i) begin
            w_pc_nxt    = bus.d_target_i;
            w_state_nxt = S_RUN;
        end else begin
            w_pc_nxt    = r_pc + 32'd4;
            w_state_nxt = S_RUN;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_BOOT;
            r_pc        <= RESET_PC;
            r_fetch_cnt <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_cnt_en) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
        end
    end

    assign bus.f_pc_o      = r_pc;
    assign bus.f_valid_o   = w_valid;
    assign bus.f_bd_o      = bus.d_is_cti_i & w_valid & ~w_flush;
    assign bus.f_adel_o    = w_adel;
    assign bus.flush_fd_o  = w_flush;
    assign bus.fetch_cnt_o = r_fetch_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fetch_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_seq
//  Brief    : Directed plus randomized bench for fetch_seq with a reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_seq;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC  = 32'h0000_4180;
    localparam logic [31:0] IM_BASE  = 32'h0000_3000;
    localparam logic [31:0] IM_TOP   = 32'h0000_6FFC;

    logic clk;
    logic reset;
    fetch_seq_if bus();

    fetch_seq #(
        .RESET_PC (RESET_PC),
        .EXC_VEC  (EXC_VEC),
        .IM_BASE  (IM_BASE),
        .IM_TOP   (IM_TOP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: current fetch address, whether the boot bubble is over, fetch tally.
    logic [31:0] m_pc;
    bit          m_live;
    logic [31:0] m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    function automatic bit legal(input logic [31:0] a);
        return (a % 4 == 0) && (a >= IM_BASE) && (a <= IM_TOP);
    endfunction

    // Called shortly after a falling edge; returns just after the next falling edge.
    task automatic cyc(input bit st, input bit rd, input logic [31:0] tg, input bit cti,
                       input bit ex, input bit er, input logic [31:0] ep);
        bit          e_flush;
        logic [31:0] e_pc;
        bus.stall_i      = st;
        bus.d_redirect_i = rd;
        bus.d_target_i   = tg;
        bus.d_is_cti_i   = cti;
        bus.exc_req_i    = ex;
        bus.eret_i       = er;
        bus.epc_i        = ep;
        #1;
        e_flush = m_live && (ex || er);
        chk("pc",    bus.f_pc_o,             m_pc);
        chk("valid", {31'd0, bus.f_valid_o}, {31'd0, m_live});
        chk("flush", {31'd0, bus.flush_fd_o}, {31'd0, e_flush});
        chk("bd",    {31'd0, bus.f_bd_o},    {31'd0, cti && m_live && !e_flush});
        chk("adel",  {31'd0, bus.f_adel_o},  {31'd0, m_live && !legal(m_pc)});
        chk("cnt",   bus.fetch_cnt_o,        m_cnt);
        @(posedge clk);
        if (!m_live) begin
            m_live = 1'b1;
        end else begin
            e_pc = m_pc;
            if (ex)       e_pc = EXC_VEC;
            else if (er)  e_pc = ep;
            else if (st)  e_pc = m_pc;
            else if (rd)  e_pc = tg;
            else          e_pc = m_pc + 32'd4;
            if (!st && !e_flush) m_cnt = m_cnt + 32'd1;
            m_pc = e_pc;
        end
        @(negedge clk);
    endtask

    task automatic adv(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 32'h0, 0, 0, 0, 32'h0);
    endtask

    // Asynchronous reset raised mid-cycle, with hostile inputs present.
    task automatic mid_reset();
        bus.stall_i   = 1'b1;
        bus.exc_req_i = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        m_pc = RESET_PC; m_live = 1'b0; m_cnt = 32'd0;
        chk("rst_pc",    bus.f_pc_o,              RESET_PC);
        chk("rst_valid", {31'd0, bus.f_valid_o},  32'd0);
        chk("rst_flush", {31'd0, bus.flush_fd_o}, 32'd0);
        chk("rst_cnt",   bus.fetch_cnt_o,         32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        logic [31:0] tg;
        logic [31:0] ep;
        int          r;
        reset = 1'b1;
        bus.stall_i = 0; bus.d_redirect_i = 0; bus.d_target_i = 0; bus.d_is_cti_i = 0;
        bus.exc_req_i = 0; bus.eret_i = 0; bus.epc_i = 0;
        m_pc = RESET_PC; m_live = 1'b0; m_cnt = 32'd0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;

        cyc(0, 0, 32'h0, 0, 0, 0, 32'h0);
        chk("boot_pc1", bus.f_pc_o, 32'h0000_3000);
        cyc(0, 0, 32'h0, 0, 0, 0, 32'h0);
        chk("boot_pc2", bus.f_pc_o, 32'h0000_3004);
        adv(3);
        chk("at_3010", bus.f_pc_o, 32'h0000_3010);
        for (int k = 0; k < 3; k++) cyc(1, 1, 32'h0000_5000, 0, 0, 0, 32'h0);
        chk("stall_pc", bus.f_pc_o, 32'h0000_3010);
        adv(1);
        chk("after_stall", bus.f_pc_o, 32'h0000_3014);
        adv(3);
        cyc(0, 1, 32'h0000_3100, 1, 0, 0, 32'h0);
        chk("redir_pc", bus.f_pc_o, 32'h0000_3100);
        cyc(1, 1, 32'h0000_3200, 1, 1, 1, 32'h0000_3300);
        chk("exc_pc", bus.f_pc_o, EXC_VEC);
        cyc(0, 0, 32'h0, 0, 0, 1, 32'h0000_3048);
        chk("eret_pc", bus.f_pc_o, 32'h0000_3048);
        cyc(0, 1, 32'h0000_3002, 0, 0, 0, 32'h0);
        cyc(0, 1, 32'h0000_7000, 0, 0, 0, 32'h0);
        chk("adel_misal_gone", bus.f_pc_o, 32'h0000_7000);
        cyc(0, 1, 32'h0000_2FFC, 0, 0, 0, 32'h0);
        cyc(0, 1, 32'h0000_6FFC, 0, 0, 0, 32'h0);
        cyc(1, 0, 32'h0, 0, 0, 0, 32'h0);
        cyc(1, 0, 32'h0, 0, 0, 0, 32'h0);
        mid_reset();
        cyc(0, 0, 32'h0, 0, 0, 0, 32'h0);
        cyc(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 32'h0);
        adv(2);
        chk("wrap_pc", bus.f_pc_o, 32'h0000_0004);

        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(3, 0);
            case (r)
                0:       tg = IM_BASE + {$urandom_range(32'h0FFF, 0), 2'b00};
                1:       tg = $urandom;
                default: tg = IM_BASE + {18'd0, $urandom_range(16'h3FFF, 0)};
            endcase
            ep = ($urandom_range(1, 0) == 1) ? IM_BASE + {$urandom_range(32'h0FFF, 0), 2'b00} : $urandom;
            if ($urandom_range(99, 0) < 2) begin
                mid_reset();
            end else begin
                cyc($urandom_range(99, 0) < 25, $urandom_range(99, 0) < 20, tg,
                    $urandom_range(99, 0) < 30, $urandom_range(99, 0) < 6,
                    $urandom_range(99, 0) < 6, ep);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
